// File: rtl/shift_deserializer.sv
// Serial-to-parallel deserializer with selectable shift direction, sticky overrun flag and tri-state Q.
// Define SHIFT_DESERIALIZER_PARITY_EN to add a trailing even-parity bit per frame and the PERR check.
module shift_deserializer #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             NoRST,
    input  logic             START,
    input  logic             DIR,
    input  logic             SEN,
    input  logic             SIN,
    input  logic             NoOE,
    output logic [WIDTH-1:0] Q,
    output logic             Q_VALID,
    output logic             BUSY,
    output logic             OVR,
    output logic             PERR
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

`ifdef SHIFT_DESERIALIZER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             q_valid_q, q_valid_d;
    logic             ovr_q, ovr_d;
    logic [WIDTH-1:0] shifted;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
    logic             perr_q, perr_d;
`endif

    // NOTE: every register here, including the word registers, is reset; the block is small
    // and a defined Q after reset is part of the interface contract.
    always_ff @(posedge CLK or negedge NoRST) begin
        if (!NoRST) begin
            state_q   <= IDLE;
            sreg_q    <= '0;
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
            ovr_q     <= 1'b0;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
            perr_q    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            ovr_q     <= ovr_d;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
            perr_q    <= perr_d;
`endif
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
        state_d   = state_q;
        sreg_d    = sreg_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        q_d       = q_q;
        q_valid_d = 1'b0;
        ovr_d     = ovr_q;
        shifted   = dir_q ? {SIN, sreg_q[WIDTH-1:1]} : {sreg_q[WIDTH-2:0], SIN};
`ifdef SHIFT_DESERIALIZER_PARITY_EN
        perr_d    = perr_q;
`endif
        case (state_q)
            IDLE: begin
                if (START) begin
                    cnt_d   = '0;
                    sreg_d  = '0;
                    dir_d   = DIR;
                    ovr_d   = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (START) ovr_d = 1'b1;
                if (SEN) begin
                    sreg_d = shifted;
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == LAST_BIT) begin
`ifdef SHIFT_DESERIALIZER_PARITY_EN
                        state_d = PARITY;
`else
                        q_d       = shifted;
                        q_valid_d = 1'b1;
                        state_d   = IDLE;
`endif
                    end
                end
            end
`ifdef SHIFT_DESERIALIZER_PARITY_EN
            PARITY: begin
                if (START) ovr_d = 1'b1;
                if (SEN) begin
                    q_d       = sreg_q;
                    q_valid_d = 1'b1;
                    perr_d    = (^sreg_q) ^ SIN;
                    state_d   = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Output enable gates only the Q drivers; everything else is visible regardless.
    always_comb begin
        BUSY    = (state_q != IDLE);
        Q       = NoOE ? {WIDTH{1'bz}} : q_q;
        Q_VALID = q_valid_q;
        OVR     = ovr_q;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
        PERR    = perr_q;
`else
        PERR    = 1'b0;
`endif
    end

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed, table-driven bench for shift_deserializer (WIDTH=4), with hand-written multi-cycle sequences.
module tb_shift_deserializer;

`ifdef SHIFT_DESERIALIZER_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       NoRST, START, DIR, SEN, SIN, NoOE;
    logic [3:0] Q;
    logic       Q_VALID, BUSY, OVR, PERR;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       dir;
        logic [3:0] bits;     // bits[3] is sent first
        logic       par;
        logic [3:0] exp_q;
        logic       exp_perr;
    } vec_t;

    vec_t vecs [7];

    shift_deserializer #(.WIDTH(4)) dut (
        .CLK(CLK), .NoRST(NoRST), .START(START), .DIR(DIR), .SEN(SEN), .SIN(SIN),
        .NoOE(NoOE), .Q(Q), .Q_VALID(Q_VALID), .BUSY(BUSY), .OVR(OVR), .PERR(PERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_frame(input logic d);
        START = 1'b1;
        DIR   = d;
        step();
        START = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        SEN = 1'b1;
        SIN = b;
        step();
        SEN = 1'b0;
    endtask

    task automatic end_frame(input logic p);
        if (PAR_EN) send_bit(p);
    endtask

    initial begin
        vecs[0] = '{dir: 1'b0, bits: 4'b1011, par: 1'b1, exp_q: 4'b1011, exp_perr: 1'b0};
        vecs[1] = '{dir: 1'b1, bits: 4'b1011, par: 1'b1, exp_q: 4'b1101, exp_perr: 1'b0};
        vecs[2] = '{dir: 1'b0, bits: 4'b0001, par: 1'b0, exp_q: 4'b0001, exp_perr: 1'b1};
        vecs[3] = '{dir: 1'b1, bits: 4'b1000, par: 1'b1, exp_q: 4'b0001, exp_perr: 1'b0};
        vecs[4] = '{dir: 1'b0, bits: 4'b1111, par: 1'b1, exp_q: 4'b1111, exp_perr: 1'b1};
        vecs[5] = '{dir: 1'b1, bits: 4'b0110, par: 1'b0, exp_q: 4'b0110, exp_perr: 1'b0};
        vecs[6] = '{dir: 1'b0, bits: 4'b1011, par: 1'b0, exp_q: 4'b1011, exp_perr: 1'b1};

        NoRST = 1'b0; START = 1'b0; DIR = 1'b0; SEN = 1'b0; SIN = 1'b0; NoOE = 1'b0;
        #12;
        check("rst_q", Q, 4'h0);
        check("rst_valid", Q_VALID, 1'b0);
        check("rst_busy", BUSY, 1'b0);
        check("rst_ovr", OVR, 1'b0);
        check("rst_perr", PERR, 1'b0);
        NoRST = 1'b1;
        step();

        foreach (vecs[v]) begin
            start_frame(vecs[v].dir);
            check($sformatf("v%0d_busy_start", v), BUSY, 1'b1);
            for (int i = 3; i >= 0; i--) send_bit(vecs[v].bits[i]);
            end_frame(vecs[v].par);
            check($sformatf("v%0d_q", v), Q, vecs[v].exp_q);
            check($sformatf("v%0d_valid", v), Q_VALID, 1'b1);
            check($sformatf("v%0d_busy_end", v), BUSY, 1'b0);
            check($sformatf("v%0d_ovr", v), OVR, 1'b0);
            check($sformatf("v%0d_perr", v), PERR, PAR_EN ? vecs[v].exp_perr : 1'b0);
            step();
            check($sformatf("v%0d_valid_pulse", v), Q_VALID, 1'b0);
        end

        // SEN gaps: Q and PERR must hold until the frame really completes
        start_frame(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        SIN = 1'b1;
        step();
        step();
        check("gap_q_hold", Q, 4'b1011);
        check("gap_busy", BUSY, 1'b1);
        check("gap_perr_hold", PERR, PAR_EN);
        send_bit(1'b0);
        check("gap_q_hold3", Q, 4'b1011);
        send_bit(1'b0);
        end_frame(1'b0);
        check("gap_q", Q, 4'b1100);
        check("gap_valid", Q_VALID, 1'b1);
        step();

        // SEN while idle does nothing
        SEN = 1'b1; SIN = 1'b1;
        step();
        SEN = 1'b0;
        check("idle_sen_busy", BUSY, 1'b0);
        check("idle_sen_q", Q, 4'b1100);
        check("idle_sen_valid", Q_VALID, 1'b0);

        // START mid-frame: overrun, frame completes normally, next START clears OVR
        start_frame(1'b0);
        send_bit(1'b1);
        START = 1'b1;
        send_bit(1'b0);
        START = 1'b0;
        check("ovr_set", OVR, 1'b1);
        check("ovr_busy", BUSY, 1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        end_frame(1'b1);
        check("ovr_q", Q, 4'b1011);
        check("ovr_sticky", OVR, 1'b1);
        step();
        start_frame(1'b0);
        check("ovr_clear", OVR, 1'b0);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        end_frame(1'b0);
        check("ovr_next_q", Q, 4'b0101);
        step();

        // NoOE high through a whole frame must not disturb the flags or the stored word
        NoOE = 1'b1;
        start_frame(1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        end_frame(1'b0);
        check("oe_valid", Q_VALID, 1'b1);
        check("oe_busy", BUSY, 1'b0);
        NoOE = 1'b0;
        #1;
        check("oe_q", Q, 4'b1001);
        step();

        // START on the final sampled cycle: ignored for framing, but flags overrun
        start_frame(1'b0);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        START = 1'b1;
        if (PAR_EN) begin
            send_bit(1'b0);
            send_bit(1'b1);
        end else begin
            send_bit(1'b0);
        end
        START = 1'b0;
        check("last_start_q", Q, 4'b1110);
        check("last_start_ovr", OVR, 1'b1);
        check("last_start_busy", BUSY, 1'b0);
        step();
        check("last_start_idle", BUSY, 1'b0);

        // Asynchronous reset mid-frame, then a clean frame
        start_frame(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        #2 NoRST = 1'b0;
        #1;
        check("arst_q", Q, 4'h0);
        check("arst_busy", BUSY, 1'b0);
        check("arst_ovr", OVR, 1'b0);
        check("arst_valid", Q_VALID, 1'b0);
        check("arst_perr", PERR, 1'b0);
        @(negedge CLK);
        NoRST = 1'b1;
        step();
        check("arst_idle", BUSY, 1'b0);
        start_frame(1'b0);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        end_frame(1'b0);
        check("arst_new_q", Q, 4'b0110);
        check("arst_new_valid", Q_VALID, 1'b1);
        check("arst_new_perr", PERR, 1'b0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
